// File: rtl/br_predict_bht_pkg.sv
// br_pred_pkg: opcode/funct3 codes, PC-select encoding and BTB entry layout
// shared by the branch predictor, its storage bank and its bus interface.
package br_pred_pkg;

    // opcode[6:2] of the control-transfer instructions
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // Branch condition codes (funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Entry fields are sized for the widest legal configuration; narrower
    // configurations zero-extend, so the unused upper bits are constant.
    localparam int BTB_TAG_MAX_W = 30;
    localparam int BTB_CTR_MAX_W = 8;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'b00,
        PC_ALU     = 2'b01,
        PC_FOUR_EX = 2'b10,
        PC_PRED    = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
        logic                     is_jump;
        logic [BTB_CTR_MAX_W-1:0] ctr;
    } btb_entry_t;

    // Saturated (all-ones) value of a w-bit counter
    function automatic logic [BTB_CTR_MAX_W-1:0] ctr_max(input int w);
        logic [BTB_CTR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BTB_CTR_MAX_W; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Weakly not taken: 01..1
    function automatic logic [BTB_CTR_MAX_W-1:0] ctr_weak_nt(input int w);
        return ctr_max(w) >> 1;
    endfunction

    // Weakly taken: 10..0, also the predict-taken threshold
    function automatic logic [BTB_CTR_MAX_W-1:0] ctr_weak_t(input int w);
        return ctr_weak_nt(w) + BTB_CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/br_predict_bht_if.sv
// br_predict_bht_if: IF lookup and EX resolve signals between the pipeline
// (master) and the branch predictor (slave).
interface br_predict_bht_if;
    import br_pred_pkg::*;

    // IF side
    logic [31:0] i_pc_if;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_btb_hit;

    // EX / ID side
    logic [31:0] i_instr_ex;
    logic        i_valid_ex;
    logic        i_stall_ex;
    logic [31:0] i_pc_ex;
    logic [31:0] i_pc_four_ex;
    logic [31:0] i_alu_ex;
    logic        i_brc_equal;
    logic        i_brc_less;
    logic [31:0] i_pc_id;
    logic        i_valid_id;

    // Redirect / hazard side
    logic        o_ctrl;
    logic        o_mispred;
    logic        o_flush;
    pc_sel_e     o_pc_sel;

    modport slave (
        input  i_pc_if, i_instr_ex, i_valid_ex, i_stall_ex, i_pc_ex, i_pc_four_ex,
               i_alu_ex, i_brc_equal, i_brc_less, i_pc_id, i_valid_id,
        output o_pred_taken, o_pred_target, o_btb_hit, o_ctrl, o_mispred,
               o_flush, o_pc_sel
    );

    modport master (
        output i_pc_if, i_instr_ex, i_valid_ex, i_stall_ex, i_pc_ex, i_pc_four_ex,
               i_alu_ex, i_brc_equal, i_brc_less, i_pc_id, i_valid_id,
        input  o_pred_taken, o_pred_target, o_btb_hit, o_ctrl, o_mispred,
               o_flush, o_pc_sel
    );

endinterface

// File: rtl/br_predict_bht_btb_bank.sv
// br_btb_bank: direct-mapped BTB storage. Async read for the IF lookup and
// for the EX training lookup, one synchronous write port from EX, and an
// asynchronous reset that invalidates every entry.
module br_btb_bank
    import br_pred_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_if_idx,
    output btb_entry_t       o_if_entry,
    input  logic [IDX_W-1:0] i_ex_idx,
    output btb_entry_t       o_ex_entry,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  btb_entry_t       i_wr_entry
);

    localparam int NENT = 1 << IDX_W;

    localparam btb_entry_t RST_ENTRY = '{
        valid:   1'b0,
        tag:     '0,
        target:  '0,
        is_jump: 1'b0,
        ctr:     ctr_weak_nt(CTR_W)
    };

    btb_entry_t r_mem [NENT];

    // Entry array: whole-table init on reset, single-entry write otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                r_mem[i] <= RST_ENTRY;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_entry;
        end
    end

    // No write bypass: a same-cycle update shows up on the next cycle
    assign o_if_entry = r_mem[i_if_idx];
    assign o_ex_entry = r_mem[i_ex_idx];

endmodule

// File: rtl/br_predict_bht.sv
// br_predict_bht: BTB-based branch predictor with 2-bit style saturating
// counters. IF gets target + taken prediction; EX resolves, trains the
// table and requests flush/redirect.
// Optional macro BR_PREDICT_PERF_EN adds o_perf_br / o_perf_mis counters.
module br_predict_bht
    import br_pred_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CTR_W = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    br_predict_bht_if.slave         bus
`ifdef BR_PREDICT_PERF_EN
    ,
    output logic [31:0]             o_perf_br,
    output logic [31:0]             o_perf_mis
`endif
);

    localparam logic [BTB_CTR_MAX_W-1:0] CTR_SAT = ctr_max(CTR_W);
    localparam logic [BTB_CTR_MAX_W-1:0] CTR_THR = ctr_weak_t(CTR_W);

    logic [IDX_W-1:0]         w_idx_if;
    logic [IDX_W-1:0]         w_idx_ex;
    logic [BTB_TAG_MAX_W-1:0] w_tag_if;
    logic [BTB_TAG_MAX_W-1:0] w_tag_ex;
    btb_entry_t               w_ent_if;
    btb_entry_t               w_ent_ex;
    btb_entry_t               w_wr_entry;
    logic                     w_wr_en;
    logic                     w_hit_if;
    logic                     w_hit_ex;
    logic                     w_pred_taken;

    logic [4:0]               w_opc;
    logic [2:0]               w_f3;
    logic                     w_is_br;
    logic                     w_is_jal;
    logic                     w_is_jalr;
    logic                     w_ctrl;
    logic                     w_cond;
    logic                     w_taken;
    logic [31:0]              w_act_next;
    logic                     w_res;
    logic                     w_mispred;
    logic [BTB_CTR_MAX_W-1:0] w_ctr_inc;
    logic [BTB_CTR_MAX_W-1:0] w_ctr_dec;

    assign w_idx_if = bus.i_pc_if[IDX_W+1:2];
    assign w_tag_if = BTB_TAG_MAX_W'(bus.i_pc_if[IDX_W+TAG_W+1:IDX_W+2]);
    assign w_idx_ex = bus.i_pc_ex[IDX_W+1:2];
    assign w_tag_ex = BTB_TAG_MAX_W'(bus.i_pc_ex[IDX_W+TAG_W+1:IDX_W+2]);

    br_btb_bank #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_if_idx   (w_idx_if),
        .o_if_entry (w_ent_if),
        .i_ex_idx   (w_idx_ex),
        .o_ex_entry (w_ent_ex),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx_ex),
        .i_wr_entry (w_wr_entry)
    );

    // IF prediction; reset clears every valid bit, so hits drop at once
    assign w_hit_if     = w_ent_if.valid && (w_ent_if.tag == w_tag_if);
    assign w_pred_taken = w_hit_if && (w_ent_if.is_jump || (w_ent_if.ctr >= CTR_THR));

    assign bus.o_btb_hit     = w_hit_if;
    assign bus.o_pred_taken  = w_pred_taken;
    assign bus.o_pred_target = w_hit_if ? w_ent_if.target : 32'd0;

    // EX decode
    assign w_opc     = bus.i_instr_ex[6:2];
    assign w_f3      = bus.i_instr_ex[14:12];
    assign w_is_br   = (w_opc == OP_BRANCH);
    assign w_is_jal  = (w_opc == OP_JAL);
    assign w_is_jalr = (w_opc == OP_JALR);
    assign w_ctrl    = w_is_br || w_is_jal || w_is_jalr;

    // Branch condition; reserved funct3 codes resolve not taken
    always_comb begin
        w_cond = 1'b0;
        case (w_f3)
            F3_BEQ:  w_cond = bus.i_brc_equal;
            F3_BNE:  w_cond = !bus.i_brc_equal;
            F3_BLT:  w_cond = bus.i_brc_less;
            F3_BGE:  w_cond = !bus.i_brc_less;
            F3_BLTU: w_cond = bus.i_brc_less;
            F3_BGEU: w_cond = !bus.i_brc_less;
            default: w_cond = 1'b0;
        endcase
    end

    // Resolution: compare the real next PC with what was actually fetched
    assign w_taken    = w_is_jal || w_is_jalr || (w_is_br && w_cond);
    assign w_act_next = w_taken ? bus.i_alu_ex : bus.i_pc_four_ex;
    assign w_res      = bus.i_valid_ex && !bus.i_stall_ex && bus.i_valid_id;
    assign w_mispred  = w_res && (bus.i_pc_id != w_act_next);

    assign bus.o_ctrl    = w_ctrl;
    assign bus.o_mispred = w_mispred;
    assign bus.o_flush   = w_mispred;

    // Next-PC select: EX redirect wins over the IF prediction
    always_comb begin
        bus.o_pc_sel = PC_PLUS4;
        if (w_mispred) begin
            bus.o_pc_sel = w_taken ? PC_ALU : PC_FOUR_EX;
        end else if (w_pred_taken) begin
            bus.o_pc_sel = PC_PRED;
        end
    end

    assign w_hit_ex  = w_ent_ex.valid && (w_ent_ex.tag == w_tag_ex);
    assign w_ctr_inc = (w_ent_ex.ctr == CTR_SAT) ? w_ent_ex.ctr : w_ent_ex.ctr + BTB_CTR_MAX_W'(1);
    assign w_ctr_dec = (w_ent_ex.ctr == '0) ? w_ent_ex.ctr : w_ent_ex.ctr - BTB_CTR_MAX_W'(1);

    // Training: build the entry written back at the EX index
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_ent_ex;
        if (bus.i_valid_ex && !bus.i_stall_ex) begin
            if (w_is_br) begin
                if (w_hit_ex) begin
                    w_wr_en        = 1'b1;
                    w_wr_entry.ctr = w_taken ? w_ctr_inc : w_ctr_dec;
                    if (w_taken) w_wr_entry.target = bus.i_alu_ex;
                end else if (w_taken) begin
                    w_wr_en    = 1'b1;
                    w_wr_entry = '{
                        valid:   1'b1,
                        tag:     w_tag_ex,
                        target:  bus.i_alu_ex,
                        is_jump: 1'b0,
                        ctr:     CTR_THR
                    };
                end
            end else if (w_is_jal || w_is_jalr) begin
                w_wr_en            = 1'b1;
                w_wr_entry.valid   = 1'b1;
                w_wr_entry.tag     = w_tag_ex;
                w_wr_entry.target  = bus.i_alu_ex;
                w_wr_entry.is_jump = 1'b1;
            end else if (w_hit_ex) begin
                // A non-control instruction matched: drop the aliased entry
                w_wr_en          = 1'b1;
                w_wr_entry.valid = 1'b0;
            end
        end
    end

`ifdef BR_PREDICT_PERF_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;

    // Saturating counts of resolved control instructions and mispredicts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_res && w_ctrl && (r_perf_br != 32'hFFFF_FFFF)) r_perf_br <= r_perf_br + 32'd1;
            if (w_mispred && (r_perf_mis != 32'hFFFF_FFFF)) r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign o_perf_br  = r_perf_br;
    assign o_perf_mis = r_perf_mis;
`endif

endmodule
